// File: rtl/anim_sprite_src_if.sv
// Sprite RAM write bus: a loader drives pixel codes into the sprite store.
interface anim_sprite_src_if #(
  parameter int ADDR     = 10,
  parameter int PLT_BITS = 2
);
  logic                we;
  logic [ADDR-1:0]     addr_w;
  logic [PLT_BITS-1:0] pixel_in;

  modport master (output we, addr_w, pixel_in);
  modport slave  (input  we, addr_w, pixel_in);
endinterface

// File: rtl/anim_sprite_src.sv
// Animated, mirrorable sprite source: 2-stage pixel pipeline (RAM read, palette)
// with a frame-tick driven animation sequencer.
module anim_sprite_src #(
  parameter int             CD         = 12,
  parameter int             H_SIZE     = 16,
  parameter int             V_SIZE     = 16,
  parameter int             NUM_FRAMES = 4,
  parameter int             PLT_BITS   = 2,
  parameter int             ANI_DIV    = 8,
  parameter logic [CD-1:0]  KEY_COLOR  = '0,
  localparam int            FID_W      = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1,
  localparam int            HB         = $clog2(H_SIZE),
  localparam int            VB         = $clog2(V_SIZE),
  localparam int            ADDR       = FID_W + VB + HB
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [10:0]       x,
  input  logic [10:0]       y,
  input  logic [10:0]       x0,
  input  logic [10:0]       y0,
  input  logic [FID_W-1:0]  frame_sel,
  input  logic              auto_en,
  input  logic              hflip,
  input  logic              vflip,
  input  logic [CD-1:0]     body_color,
  anim_sprite_src_if.slave  wr,
  output logic [CD-1:0]     sprite_rgb,
  output logic              sprite_hit,
  output logic [FID_W-1:0]  cur_frame
);

  localparam logic [7:0] DIV_LAST = 8'(ANI_DIV - 1);

  typedef enum logic {MANUAL, AUTO} state_t;

  logic [11:0]         xr;
  logic [11:0]         yr;
  logic                in_region;
  logic [HB-1:0]       col;
  logic [VB-1:0]       row;
  logic [ADDR-1:0]     rd_addr;
  logic [PLT_BITS-1:0] mem [1<<ADDR];
  logic [PLT_BITS-1:0] rd_code;
  logic                in_region_s1;
  logic [CD-1:0]       pal_rgb;
  logic                pal_hit;
  logic [10:0]         prev_x;
  logic [10:0]         prev_y;
  logic                tick;
  state_t              state;
  logic [7:0]          tick_cnt;
  logic [FID_W-1:0]    frame_next;
  logic [FID_W-1:0]    frame_manual;

  // Zero-extended 12-bit difference: bit 11 set means the scan is left/above the origin.
  assign xr        = {1'b0, x} - {1'b0, x0};
  assign yr        = {1'b0, y} - {1'b0, y0};
  assign in_region = !xr[11] && (xr < 12'(H_SIZE)) && !yr[11] && (yr < 12'(V_SIZE));

  // Mirroring N-1-v on a power-of-two field is just a bitwise inversion.
  assign col     = hflip ? ~xr[HB-1:0] : xr[HB-1:0];
  assign row     = vflip ? ~yr[VB-1:0] : yr[VB-1:0];
  assign rd_addr = {cur_frame, row, col};

  // Read-before-write: a same-address read in the write cycle sees the old code.
  always_ff @(posedge clk) begin
    if (wr.we) begin
      mem[wr.addr_w] <= wr.pixel_in;
    end
    rd_code <= mem[rd_addr];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_region_s1 <= 1'b0;
    end else begin
      in_region_s1 <= in_region;
    end
  end

  always_comb begin
    pal_rgb = KEY_COLOR;
    pal_hit = 1'b0;
    if (in_region_s1) begin
      case (rd_code)
        PLT_BITS'(0): begin
          pal_rgb = KEY_COLOR;
          pal_hit = 1'b0;
        end
        PLT_BITS'(1): begin
          pal_rgb = '1;
          pal_hit = 1'b1;
        end
        PLT_BITS'(2): begin
          pal_rgb = body_color;
          pal_hit = 1'b1;
        end
        PLT_BITS'(3): begin
          pal_rgb = '0;
          pal_hit = 1'b1;
        end
        default: begin
          pal_rgb = '1;
          pal_hit = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sprite_rgb <= KEY_COLOR;
      sprite_hit <= 1'b0;
    end else begin
      sprite_rgb <= pal_rgb;
      sprite_hit <= pal_hit;
    end
  end

  // Previous position starts off-origin so the first (0,0) after reset ticks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_x <= 11'h7FF;
      prev_y <= 11'h7FF;
    end else begin
      prev_x <= x;
      prev_y <= y;
    end
  end

  assign tick = (x == '0) && (y == '0) && !((prev_x == '0) && (prev_y == '0));

  assign frame_next   = (NUM_FRAMES == 1) ? '0 : cur_frame + FID_W'(1);
  assign frame_manual = (NUM_FRAMES == 1) ? '0 : frame_sel;

  // The state register is the registered auto_en; cur_frame updates after the tick
  // cycle, so the tick pixel itself still reads the old frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= MANUAL;
      cur_frame <= '0;
      tick_cnt  <= '0;
    end else begin
      state <= auto_en ? AUTO : MANUAL;
      case (state)
        MANUAL: begin
          cur_frame <= frame_manual;
          tick_cnt  <= '0;
        end
        AUTO: begin
          if (tick) begin
            if (tick_cnt == DIV_LAST) begin
              tick_cnt  <= '0;
              cur_frame <= frame_next;
            end else begin
              tick_cnt <= tick_cnt + 8'd1;
            end
          end
        end
        default: begin
          cur_frame <= frame_manual;
          tick_cnt  <= '0;
        end
      endcase
    end
  end

endmodule
